// File: rtl/defog_pkg.sv
// Shared types and constants for the dark-channel-prior defog pipeline.
package defog_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned RC_W   = 12;
  localparam int unsigned PROD_W = 22;
  localparam int unsigned OMEGA  = 230;
  localparam int unsigned T0     = 26;
  localparam int unsigned LUT_N  = 256;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  // round(65280/t); entries below T0 never get addressed and are left at 0
  function automatic logic [RC_W-1:0] recip(input logic [PIX_W-1:0] t);
    int unsigned tv;
    tv = 32'(t);
    if (tv < T0) return '0;
    return RC_W'((32'd65280 + tv / 2) / tv);
  endfunction

endpackage

// File: rtl/defog_recover.sv
// Per-channel scene recovery: J = A + ((I-A)*Rc >>> 8), saturated to 0..255.
module defog_recover
  import defog_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] atm,
  input  logic [RC_W-1:0]  rc,
  output logic [PIX_W-1:0] result
);

  localparam int unsigned SUM_W = PROD_W + 1;

  logic        [PIX_W:0]    d_c;
  logic signed [PROD_W-1:0] d_ext;
  logic signed [PROD_W-1:0] rc_ext;
  logic signed [PROD_W-1:0] p_c;
  logic signed [PROD_W-1:0] p_q;
  logic signed [PROD_W-1:0] q_c;
  logic        [SUM_W-1:0]  sum_c;
  logic        [PIX_W-1:0]  sat_c;

  // S3: signed difference times the transmission reciprocal
  assign d_c    = {1'b0, pix} - {1'b0, atm};
  assign d_ext  = {{(PROD_W-PIX_W-1){d_c[PIX_W]}}, d_c};
  assign rc_ext = {{(PROD_W-RC_W){1'b0}}, rc};
  assign p_c    = d_ext * rc_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p_q <= '0;
    else          p_q <= p_c;
  end

  // S4: floor shift, add A back, clamp
  assign q_c   = p_q >>> 8;
  assign sum_c = {q_c[PROD_W-1], q_c} + {{(SUM_W-PIX_W){1'b0}}, atm};

  always_comb begin
    sat_c = sum_c[PIX_W-1:0];
    if (sum_c[SUM_W-1])              sat_c = '0;
    else if (|sum_c[SUM_W-2:PIX_W])  sat_c = '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) result <= '0;
    else          result <= sat_c;
  end

endmodule

// File: rtl/defog_core.sv
// Streaming haze removal: dark channel, transmission, recovery, per-frame max dark.
module defog_core
  import defog_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] r_in,
  input  logic [PIX_W-1:0] g_in,
  input  logic [PIX_W-1:0] b_in,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             en,
  input  logic             frame_done,
  input  logic [PIX_W-1:0] atm_light,
  output logic [PIX_W-1:0] r_out,
  output logic [PIX_W-1:0] g_out,
  output logic [PIX_W-1:0] b_out,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_en,
  output logic [PIX_W-1:0] max_of_dark
);

  localparam int unsigned SYNC_W = 3;
  localparam logic [PIX_W-1:0] T0_PIX = PIX_W'(T0);

  logic [PIX_W-1:0]  dark_c;
  logic [15:0]       m_prod_c;
  logic [PIX_W-1:0]  t_c;
  logic [RC_W-1:0]   rc_c;
  logic [RC_W-1:0]   rc_rom [LUT_N];

  rgb_t              s1_pix, s2_pix;
  logic [PIX_W-1:0]  s1_dark, s2_t, acc;
  logic [SYNC_W-1:0] s1_sync, s2_sync, s3_sync, s4_sync;

  // S1: dark channel
  always_comb begin
    dark_c = r_in;
    if (g_in < dark_c) dark_c = g_in;
    if (b_in < dark_c) dark_c = b_in;
  end

  // S2: transmission, floored at T0
  assign m_prod_c = 16'(s1_dark) * 16'(OMEGA);
  always_comb begin
    t_c = 8'd255 - m_prod_c[15:8];
    if (t_c < T0_PIX) t_c = T0_PIX;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_pix  <= '0;
      s1_dark <= '0;
      s1_sync <= '0;
      s2_pix  <= '0;
      s2_t    <= '0;
      s2_sync <= '0;
      s3_sync <= '0;
      s4_sync <= '0;
    end else begin
      s1_pix  <= '{r: r_in, g: g_in, b: b_in};
      s1_dark <= dark_c;
      s1_sync <= {hsync, vsync, en};
      s2_pix  <= s1_pix;
      s2_t    <= t_c;
      s2_sync <= s1_sync;
      s3_sync <= s2_sync;
      s4_sync <= s3_sync;
    end
  end

  assign {o_hsync, o_vsync, o_en} = s4_sync;

  // One constant reciprocal table shared by all three channels
  for (genvar i = 0; i < LUT_N; i++) begin : g_rom
    localparam logic [RC_W-1:0] RC_VAL = recip(PIX_W'(i));
    assign rc_rom[i] = RC_VAL;
  end
  assign rc_c = rc_rom[s2_t];

  defog_recover u_rec_r (
    .clk(clk), .reset_n(reset_n), .pix(s2_pix.r), .atm(atm_light), .rc(rc_c), .result(r_out)
  );
  defog_recover u_rec_g (
    .clk(clk), .reset_n(reset_n), .pix(s2_pix.g), .atm(atm_light), .rc(rc_c), .result(g_out)
  );
  defog_recover u_rec_b (
    .clk(clk), .reset_n(reset_n), .pix(s2_pix.b), .atm(atm_light), .rc(rc_c), .result(b_out)
  );

  // Per-frame max dark; frame_done publishes and restarts, folding in the S1 pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      max_of_dark <= '0;
    end else if (frame_done) begin
      max_of_dark <= (s1_sync[0] && (s1_dark > acc)) ? s1_dark : acc;
      acc         <= s1_sync[0] ? s1_dark : '0;
    end else if (s1_sync[0] && (s1_dark > acc)) begin
      acc <= s1_dark;
    end
  end

endmodule

// File: tb/tb_defog_core.sv
// Directed self-checking bench for defog_core with A = 8'hC5.
module tb_defog_core;

  logic       clk;
  logic       reset_n;
  logic [7:0] r_in, g_in, b_in;
  logic       hsync, vsync, en, frame_done;
  logic [7:0] atm_light;
  logic [7:0] r_out, g_out, b_out;
  logic       o_hsync, o_vsync, o_en;
  logic [7:0] max_of_dark;

  int checks   = 0;
  int failures = 0;

  int unsigned vec_in  [4][3] = '{'{0, 0, 0}, '{200, 100, 50}, '{255, 255, 255}, '{10, 0, 5}};
  int unsigned vec_out [4][3] = '{'{0, 0, 0}, '{200, 79, 19},  '{255, 255, 255}, '{10, 0, 5}};

  defog_core dut (
    .clk(clk), .reset_n(reset_n),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync(hsync), .vsync(vsync), .en(en),
    .frame_done(frame_done), .atm_light(atm_light),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_en(o_en),
    .max_of_dark(max_of_dark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned r, input int unsigned g, input int unsigned b, input logic e);
    r_in  = 8'(r);
    g_in  = 8'(g);
    b_in  = 8'(b);
    hsync = e;
    vsync = 1'b0;
    en    = e;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({r_out, g_out, b_out} !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb got=%h want=000000", {r_out, g_out, b_out});
    end
    checks++;
    if ({o_hsync, o_vsync, o_en} !== 3'b000 || max_of_dark !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl sync=%b max=%0d want sync=000 max=0", {o_hsync, o_vsync, o_en}, max_of_dark);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_pixels();
    for (int i = 0; i < 4; i++) begin
      drive(vec_in[i][0], vec_in[i][1], vec_in[i][2], 1'b1);
      step();
      drive(0, 0, 0, 1'b0);
      step(); step();
      checks++;
      if (o_en !== 1'b0) begin
        failures++;
        $display("FAIL pix%0d_early o_en=%b want 0", i, o_en);
      end
      step();
      checks++;
      if ({r_out, g_out, b_out} !== {8'(vec_out[i][0]), 8'(vec_out[i][1]), 8'(vec_out[i][2])}) begin
        failures++;
        $display("FAIL pix%0d_rgb got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, r_out, g_out, b_out,
                 vec_out[i][0], vec_out[i][1], vec_out[i][2]);
      end
      checks++;
      if (o_en !== 1'b1 || o_hsync !== 1'b1) begin
        failures++;
        $display("FAIL pix%0d_sync o_en=%b o_hsync=%b want 1 1", i, o_en, o_hsync);
      end
      step(); step();
    end
  endtask

  task automatic test_back_to_back();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 4) drive(vec_in[cyc][0], vec_in[cyc][1], vec_in[cyc][2], 1'b1);
      else         drive(0, 0, 0, 1'b0);
      step();
      if (cyc >= 3 && cyc < 7) begin
        checks++;
        if ({r_out, g_out, b_out} !== {8'(vec_out[cyc-3][0]), 8'(vec_out[cyc-3][1]), 8'(vec_out[cyc-3][2])}
            || o_en !== 1'b1) begin
          failures++;
          $display("FAIL b2b%0d got=(%0d,%0d,%0d) en=%b want=(%0d,%0d,%0d) en=1", cyc - 3, r_out, g_out, b_out,
                   o_en, vec_out[cyc-3][0], vec_out[cyc-3][1], vec_out[cyc-3][2]);
        end
      end
    end
    step();
    checks++;
    if (o_en !== 1'b0) begin
      failures++;
      $display("FAIL b2b_tail o_en=%b want 0", o_en);
    end
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    step();
  endtask

  task automatic test_max();
    // Previous tests streamed darks up to 255
    pulse_frame_done();
    checks++;
    if (max_of_dark !== 8'd255) begin
      failures++;
      $display("FAIL max_prev got=%0d want=255", max_of_dark);
    end
    drive(10, 20, 30, 1'b1);    step();
    drive(200, 210, 220, 1'b1); step();
    drive(50, 60, 70, 1'b1);    step();
    drive(0, 0, 0, 1'b0);       step(); step();
    pulse_frame_done();
    checks++;
    if (max_of_dark !== 8'd200) begin
      failures++;
      $display("FAIL max_frame1 got=%0d want=200", max_of_dark);
    end
    for (int k = 0; k < 3; k++) begin
      drive(30, 30, 30, 1'b1);
      step();
    end
    drive(0, 0, 0, 1'b0);
    step(); step(); step();
    checks++;
    if (max_of_dark !== 8'd200) begin
      failures++;
      $display("FAIL max_hold got=%0d want=200", max_of_dark);
    end
    pulse_frame_done();
    checks++;
    if (max_of_dark !== 8'd30) begin
      failures++;
      $display("FAIL max_frame2 got=%0d want=30", max_of_dark);
    end
    // frame_done while the dark-99 pixel sits in S1 with en high
    drive(150, 160, 170, 1'b1); step();
    drive(99, 120, 99, 1'b1);   step();
    drive(0, 0, 0, 1'b0);
    pulse_frame_done();
    checks++;
    if (max_of_dark !== 8'd150) begin
      failures++;
      $display("FAIL max_coinc got=%0d want=150", max_of_dark);
    end
    step(); step();
    pulse_frame_done();
    checks++;
    if (max_of_dark !== 8'd99) begin
      failures++;
      $display("FAIL max_restart got=%0d want=99", max_of_dark);
    end
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 6; k++) begin
      drive(200, 100, 50, 1'b1);
      step();
    end
    checks++;
    if ({r_out, g_out, b_out} !== {8'd200, 8'd79, 8'd19}) begin
      failures++;
      $display("FAIL mid_pre got=(%0d,%0d,%0d) want=(200,79,19)", r_out, g_out, b_out);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({r_out, g_out, b_out} !== 24'h0 || o_en !== 1'b0 || max_of_dark !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset rgb=%h en=%b max=%0d want 000000 0 0", {r_out, g_out, b_out}, o_en, max_of_dark);
    end
    drive(0, 0, 0, 1'b0);
    step(); step();
    reset_n = 1'b1;
    step();
    drive(10, 0, 5, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (o_en !== 1'b0) begin
        failures++;
        $display("FAIL mid_lat%0d o_en=%b want 0", k, o_en);
      end
      step();
    end
    checks++;
    if (o_en !== 1'b1 || {r_out, g_out, b_out} !== {8'd10, 8'd0, 8'd5}) begin
      failures++;
      $display("FAIL mid_first en=%b got=(%0d,%0d,%0d) want en=1 (10,0,5)", o_en, r_out, g_out, b_out);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    frame_done = 1'b0;
    atm_light  = 8'hC5;
    drive(0, 0, 0, 1'b0);
    test_reset();
    test_pixels();
    test_back_to_back();
    test_max();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
